// File: rtl/mandel_iter_if.sv
// Point/result handshake bundle between the coordinate mapper, mandel_iter and the colour stage.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the point side, out_valid/out_ready on the result side.
//
// Signals:
//   in_valid, in_ready        point handshake
//   c_re, c_im                complex point, signed 32-bit fixed point
//   in_x, in_y                pixel tag carried with the point
//   out_valid, out_ready      result handshake
//   out_iter, out_escaped     iteration count and escape flag
//   out_x, out_y              pixel tag of the result
// Modports: master = the side that drives points and consumes results, slave = the engine.
interface mandel_iter_if #(
  parameter int ITER_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       c_re;
  logic [31:0]       c_im;
  logic [9:0]        in_x;
  logic [9:0]        in_y;
  logic              out_valid;
  logic              out_ready;
  logic [ITER_W-1:0] out_iter;
  logic              out_escaped;
  logic [9:0]        out_x;
  logic [9:0]        out_y;

  modport master (
    output in_valid, c_re, c_im, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_iter, out_escaped, out_x, out_y
  );

  modport slave (
    input  in_valid, c_re, c_im, in_x, in_y, out_ready,
    output in_ready, out_valid, out_iter, out_escaped, out_x, out_y
  );
endinterface

// File: rtl/mandel_iter.sv
// Mandelbrot escape-time engine: iterates z <- z^2 + c, one iteration per clock, for one point at a time.
// Latency: result valid k+2 cycles after accept for a count of k (MAX_ITER+2 worst case).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, then IDLE on the next cycle.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; drops any in-flight point without a result
//   bus    mandel_iter_if.slave: point in (c_re, c_im, in_x, in_y), result out
//          (out_iter, out_escaped, out_x, out_y), each side with valid/ready
// Optional build macro: MANDEL_BULB_SKIP_EN - points inside the period-2 bulb
// skip iteration and report MAX_ITER directly (same result, shorter latency).
module mandel_iter #(
  parameter int MAX_ITER = 255,
  parameter int ITER_W   = 8,
  parameter int FRAC     = 21
) (
  input  logic          clk,
  input  logic          rst_n,
  mandel_iter_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // 4.0 in the coordinate format, widened so the |z|^2 compare never wraps
  localparam logic signed [63:0] ESC_LIM = 64'sd4 <<< FRAC;

  function automatic logic signed [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  logic [1:0]        state;
  logic [31:0]       c_re_q;
  logic [31:0]       c_im_q;
  logic [9:0]        x_q;
  logic [9:0]        y_q;
  logic [31:0]       z_re;
  logic [31:0]       z_im;
  logic [ITER_W-1:0] cnt;

  logic              in_ready_q;
  logic              out_valid_q;
  logic [ITER_W-1:0] out_iter_q;
  logic              out_escaped_q;
  logic [9:0]        out_x_q;
  logic [9:0]        out_y_q;

  logic signed [63:0] zr2;
  logic signed [63:0] zi2;
  logic signed [63:0] zri;
  logic signed [63:0] mag;
  logic               escape;
  logic               at_cap;
  logic [31:0]        z_re_nxt;
  logic [31:0]        z_im_nxt;

  always_comb begin
    zr2      = (sx(z_re) * sx(z_re)) >>> FRAC;
    zi2      = (sx(z_im) * sx(z_im)) >>> FRAC;
    zri      = (sx(z_re) * sx(z_im)) >>> FRAC;
    mag      = zr2 + zi2;
    escape   = mag > ESC_LIM;
    at_cap   = cnt == ITER_W'(MAX_ITER);
    // Truncation is safe: escape fires long before |z| leaves the 32-bit range.
    z_re_nxt = 32'(zr2 - zi2 + sx(c_re_q));
    z_im_nxt = 32'((zri <<< 1) + sx(c_im_q));
  end

`ifdef MANDEL_BULB_SKIP_EN
  localparam logic signed [63:0] ONE_FX   = 64'sd1 <<< FRAC;
  localparam logic signed [63:0] BULB_LIM = ONE_FX >>> 4;

  logic signed [63:0] b_re;
  logic signed [63:0] b_mag;
  logic               in_bulb;

  // Period-2 bulb: (c_re + 1)^2 + c_im^2 < 1/16, evaluated on the raw inputs.
  always_comb begin
    b_re    = sx(bus.c_re) + ONE_FX;
    b_mag   = ((b_re * b_re) >>> FRAC) + ((sx(bus.c_im) * sx(bus.c_im)) >>> FRAC);
    in_bulb = b_mag < BULB_LIM;
  end
`else
  logic in_bulb;
  assign in_bulb = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      c_re_q        <= '0;
      c_im_q        <= '0;
      x_q           <= '0;
      y_q           <= '0;
      z_re          <= '0;
      z_im          <= '0;
      cnt           <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_iter_q    <= '0;
      out_escaped_q <= 1'b0;
      out_x_q       <= '0;
      out_y_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            c_re_q     <= bus.c_re;
            c_im_q     <= bus.c_im;
            x_q        <= bus.in_x;
            y_q        <= bus.in_y;
            z_re       <= '0;
            z_im       <= '0;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            if (in_bulb) begin
              state         <= DONE;
              out_valid_q   <= 1'b1;
              out_iter_q    <= ITER_W'(MAX_ITER);
              out_escaped_q <= 1'b0;
              out_x_q       <= bus.in_x;
              out_y_q       <= bus.in_y;
            end else begin
              state <= ITER;
            end
          end
        end
        ITER: begin
          if (escape || at_cap) begin
            // Escape wins over the cap; cnt equals MAX_ITER on the cap path,
            // so the count is reported the same way for both.
            state         <= DONE;
            out_valid_q   <= 1'b1;
            out_iter_q    <= cnt;
            out_escaped_q <= escape;
            out_x_q       <= x_q;
            out_y_q       <= y_q;
          end else begin
            z_re <= z_re_nxt;
            z_im <= z_im_nxt;
            cnt  <= cnt + ITER_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_iter    = out_iter_q;
  assign bus.out_escaped = out_escaped_q;
  assign bus.out_x       = out_x_q;
  assign bus.out_y       = out_y_q;

endmodule

// File: tb/tb_mandel_iter.sv
// Directed bench for mandel_iter: hand-computed escape counts, latency, stall, reset and back-to-back.
// Latency: n/a.
// Backpressure: out_ready driven by the directed steps.
module tb_mandel_iter;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mandel_iter_if #(.ITER_W(8)) bus ();

  mandel_iter #(
    .MAX_ITER(255),
    .ITER_W  (8),
    .FRAC    (21)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present a point, wait for accept, then count cycles until out_valid.
  // lat is the cycle (accept = cycle 0) in which out_valid is first seen high.
  task automatic run_pt(input logic [31:0] cr, input logic [31:0] ci,
                        input logic [9:0] x, input logic [9:0] y, output int lat);
    int w;
    @(negedge clk);
    bus.c_re     = cr;
    bus.c_im     = ci;
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Handshake the held result and check in_ready comes back the next cycle.
  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_in_ready_after"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_out_valid_after"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    int lat;
    logic stable;
    logic ready_low;
    logic seen_valid;
    logic [7:0] h_iter;
    logic [9:0] h_x, h_y;
    int cyc, nacc, nres;
    int acc_cyc[2];
    int hs_cyc[2];
    logic [7:0] r_iter[2];
    logic [9:0] r_x[2];

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.c_re      = '0;
    bus.c_im      = '0;
    bus.in_x      = '0;
    bus.in_y      = '0;

    repeat (3) @(negedge clk);
    chk("rst_in_ready",    64'(bus.in_ready),    64'd1);
    chk("rst_out_valid",   64'(bus.out_valid),   64'd0);
    chk("rst_out_iter",    64'(bus.out_iter),    64'd0);
    chk("rst_out_escaped", 64'(bus.out_escaped), 64'd0);
    chk("rst_out_x",       64'(bus.out_x),       64'd0);
    chk("rst_out_y",       64'(bus.out_y),       64'd0);
    rst_n = 1'b1;

    // c = 0: never escapes, capped at 255, result in cycle 257
    run_pt(32'h0000_0000, 32'h0000_0000, 10'd0, 10'd0, lat);
    chk("c0_iter", 64'(bus.out_iter),    64'd255);
    chk("c0_esc",  64'(bus.out_escaped), 64'd0);
    chk("c0_lat",  64'(lat),             64'd257);
    consume("c0");

    // c = 2.0: |z|^2 sequence 0, 4, 36 -> exactly 4.0 must not escape
    run_pt(32'h0040_0000, 32'h0000_0000, 10'd5, 10'd6, lat);
    chk("c2_iter", 64'(bus.out_iter),    64'd2);
    chk("c2_esc",  64'(bus.out_escaped), 64'd1);
    chk("c2_lat",  64'(lat),             64'd4);
    consume("c2");

    // c = 1.0 tagged (37,12): z 0,1,2,5 -> count 3; then stall 5 cycles
    run_pt(32'h0020_0000, 32'h0000_0000, 10'd37, 10'd12, lat);
    chk("c1_iter", 64'(bus.out_iter),    64'd3);
    chk("c1_esc",  64'(bus.out_escaped), 64'd1);
    chk("c1_x",    64'(bus.out_x),       64'd37);
    chk("c1_y",    64'(bus.out_y),       64'd12);
    chk("c1_lat",  64'(lat),             64'd5);
    h_iter    = bus.out_iter;
    h_x       = bus.out_x;
    h_y       = bus.out_y;
    stable    = 1'b1;
    ready_low = 1'b1;
    bus.c_re     = 32'h0040_0000;
    bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!bus.out_valid || bus.out_iter !== h_iter || bus.out_x !== h_x ||
          bus.out_y !== h_y || bus.out_escaped !== 1'b1) stable = 1'b0;
      if (bus.in_ready !== 1'b0) ready_low = 1'b0;
    end
    chk("stall_stable",    64'(stable),    64'd1);
    chk("stall_ready_low", 64'(ready_low), 64'd1);
    bus.in_valid = 1'b0;
    consume("c1");

    // c = -1.0: period-2 orbit 0,-1,0,...
    run_pt(32'hFFE0_0000, 32'h0000_0000, 10'd1, 10'd2, lat);
    chk("cm1_iter", 64'(bus.out_iter),    64'd255);
    chk("cm1_esc",  64'(bus.out_escaped), 64'd0);
`ifdef MANDEL_BULB_SKIP_EN
    chk("cm1_lat",  64'(lat),             64'd1);
`else
    chk("cm1_lat",  64'(lat),             64'd257);
`endif
    consume("cm1");

    // c = -2.0: z settles at 2, |z|^2 = 4 forever, never escapes
    run_pt(32'hFFC0_0000, 32'h0000_0000, 10'd3, 10'd4, lat);
    chk("cm2_iter", 64'(bus.out_iter),    64'd255);
    chk("cm2_esc",  64'(bus.out_escaped), 64'd0);
    consume("cm2");

    // Reset in ITER cycle 50 of a new point
    @(negedge clk);
    bus.c_re     = 32'hFFC0_0000;
    bus.c_im     = 32'h0000_0000;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (49) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) seen_valid = 1'b1;
    end
    chk("mid_rst_no_result", 64'(seen_valid), 64'd0);
    run_pt(32'h0040_0000, 32'h0000_0000, 10'd9, 10'd9, lat);
    chk("post_rst_iter", 64'(bus.out_iter), 64'd2);
    consume("post_rst");

    // Back-to-back: A = 2.0 tag 1, B = 1.0 tag 2, out_ready held high
    cyc  = 0;
    nacc = 0;
    nres = 0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.c_re      = 32'h0040_0000;
    bus.in_x      = 10'd1;
    bus.in_valid  = 1'b1;
    while (nres < 2 && cyc < 100) begin
      if (nacc == 1) begin
        bus.c_re = 32'h0020_0000;
        bus.in_x = 10'd2;
      end else if (nacc == 2) begin
        bus.in_valid = 1'b0;
      end
      if (bus.in_valid && bus.in_ready && nacc < 2) begin
        acc_cyc[nacc] = cyc;
        nacc++;
      end
      if (bus.out_valid && bus.out_ready) begin
        hs_cyc[nres] = cyc;
        r_iter[nres] = bus.out_iter;
        r_x[nres]    = bus.out_x;
        nres++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("b2b_results", 64'(nres), 64'd2);
    chk("b2b_accepts", 64'(nacc), 64'd2);
    if (nres == 2 && nacc == 2) begin
      chk("b2b_accept_gap", 64'(acc_cyc[1] - hs_cyc[0]), 64'd1);
      chk("b2b_a_lat",      64'(hs_cyc[0] - acc_cyc[0]), 64'd4);
      chk("b2b_a_iter",     64'(r_iter[0]),             64'd2);
      chk("b2b_a_x",        64'(r_x[0]),                64'd1);
      chk("b2b_b_iter",     64'(r_iter[1]),             64'd3);
      chk("b2b_b_x",        64'(r_x[1]),                64'd2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mandel_iter.md
# mandel_iter

Per-pixel Mandelbrot escape-time engine sitting directly downstream of the coordinate mapper. It accepts one complex point c = (c_re, c_im) per transaction together with its pixel tag (X, Y). It iterates z ← z² + c in signed fixed point, one iteration per clock, and returns the iteration count at escape (or MAX_ITER). Valid/ready handshakes on both sides let the pixel scanner and the colour/frame-buffer stage stall it freely.

## Interface
- MAX_ITER, 255: iteration cap; must fit ITER_W bits.
- ITER_W, 8: width of the iteration count.
- FRAC, 21: fractional bits of the 32-bit two's-complement coordinate format (1.0 = 0x0020_0000).

- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  c_re/c_im/in_x/in_y are valid.
- in_ready  out  1  block can accept a point.
- c_re  in  32  real part of c, signed, FRAC fractional bits.
- c_im  in  32  imaginary part of c, same format.
- in_x, in_y  in  10 each  pixel tag, passed through untouched.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_iter  out  ITER_W  iteration count.
- out_escaped  out  1  1 = |z|² exceeded 4.0; 0 = hit MAX_ITER.
- out_x, out_y  out  10 each  tag of the result.

## Operation
- FSM states are IDLE, ITER and DONE. Reset enters IDLE.
- IDLE: in_ready=1. When in_valid && in_ready, the block latches c and the tag, clears z_re=z_im=0 and count=0, then goes to ITER.
- ITER: in_ready=0. Each cycle computes full-width signed 64-bit products: zr2=(z_re·z_re)>>>FRAC, zi2=(z_im·z_im)>>>FRAC, zri=(z_re·z_im)>>>FRAC.
  - If zr2+zi2 > 4.0 (0x0080_0000, compared in 64 bits, no wrap): out_iter=count, out_escaped=1, go to DONE.
  - Else if count == MAX_ITER: out_iter=MAX_ITER, out_escaped=0, go to DONE.
  - Else: z_re ← (zr2−zi2+c_re)[31:0], z_im ← (2·zri+c_im)[31:0], count ← count+1.
- Escape has priority over the cap when both hold in the same cycle.
- z updates truncate to 32 bits. Wrap is harmless because escape is always detected before |z| can exceed the 32-bit range.
- DONE: out_valid=1, and the outputs are held stable. On out_valid && out_ready, go to IDLE.
- Only one point is in flight at a time. There is no accept in DONE, even if out_ready is high.
- rst_n low in any state: immediate return to IDLE. The in-flight point is discarded with no result.

## Timing
- Reset values: in_ready=1, out_valid=0, out_iter=0, out_escaped=0, out_x=0, out_y=0. Internal z and count are also 0.
- Accept in cycle 0. ITER occupies cycles 1..k+1 for a result of k. out_valid goes high in cycle k+2.
- Worst case: out_valid in cycle MAX_ITER+2 (257 with defaults).
- in_ready rises the cycle after the out_valid && out_ready handshake.
- All outputs are registered. No combinational path runs from in_valid to in_ready or from out_ready to out_valid.

## Configuration
- MANDEL_BULB_SKIP_EN defined: at accept, the block evaluates the period-2 bulb test (c_re+1.0)²+c_im² < 1/16 (0x0002_0000) on the input values, using 64-bit products.
  - If the test is true, the block goes straight to DONE with out_iter=MAX_ITER and out_escaped=0, so out_valid is high in cycle 1.
  - Otherwise normal operation.
- Undefined: no bulb test and no extra logic; every point iterates.
- Results are bit-identical in both builds; only latency differs.

## Test plan
- c=0 → out_iter=255, out_escaped=0, out_valid in cycle 257.
- c_re=0x0040_0000 (2.0), c_im=0 → out_iter=2, out_escaped=1, out_valid in cycle 4. Checks the strict > 4.0 comparison at |z|²=4.
- c_re=0x0020_0000 (1.0), c_im=0, tag (37,12) → out_iter=3, escaped=1, out_x=37, out_y=12. Then out_ready held low 5 cycles → outputs stable, in_ready=0 throughout.
- c_re=0xFFE0_0000 (−1.0), c_im=0:
  - With MANDEL_BULB_SKIP_EN: out_iter=255, escaped=0, out_valid in cycle 1.
  - Without it: same result in cycle 257.
- c=(0xFFC0_0000 (−2.0), 0) → out_iter=255, escaped=0. Then rst_n pulsed low in ITER cycle 50 of a new point → out_valid never rises and in_ready=1 right after reset. A following c=2.0 gives out_iter=2.
- Back-to-back: in_valid held high with two points and out_ready=1 → the second is accepted exactly one cycle after the first result handshake, and the results appear in order.
